// File: rtl/seven_seg_display_arbiter_if.sv
// Request, grant and display bundle shared between the display arbiter and its requesters.
// The master side raises requests and reads grants; the slave side is the arbiter.
interface seven_seg_display_arbiter_if #(
    parameter int NUM_REQ = 3
);
    logic [NUM_REQ-1:0]   req_valid;
    logic [8*NUM_REQ-1:0] req_value;
    logic [NUM_REQ-1:0]   req_blank;
    logic [NUM_REQ-1:0]   grant;
    logic [NUM_REQ-1:0]   done;
    logic                 busy;
    logic [6:0]           display_1;
    logic [6:0]           display_2;

    modport master (
        output req_valid,
        output req_value,
        output req_blank,
        input  grant,
        input  done,
        input  busy,
        input  display_1,
        input  display_2
    );

    modport slave (
        input  req_valid,
        input  req_value,
        input  req_blank,
        output grant,
        output done,
        output busy,
        output display_1,
        output display_2
    );
endinterface

// File: rtl/seven_seg_display_arbiter.sv
// Round-robin owner of the two-digit seven-segment display with a minimum hold per slot.
// The granted requester's byte is decoded every cycle into two active-low cathode patterns.
module seven_seg_display_arbiter #(
    parameter int NUM_REQ     = 3,
    parameter int HOLD_CYCLES = 100000000,
    parameter int CNT_W       = 27
) (
    input  logic                          clock,
    input  logic                          reset,
    seven_seg_display_arbiter_if.slave    bus
);

    localparam int                 IDX_W     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [6:0]         SEG_BLANK = 7'b1111111;
    localparam logic [CNT_W-1:0]   HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0]   HOLD_WARN = CNT_W'(HOLD_CYCLES - 2);
    localparam logic [NUM_REQ-1:0] ONE_HOT0  = {{(NUM_REQ-1){1'b0}}, 1'b1};
    localparam logic [NUM_REQ-1:0] NONE      = {NUM_REQ{1'b0}};

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        SHOW = 1'b1
    } state_t;

    function automatic logic [6:0] seg_decode(input logic [3:0] nib);
        logic [6:0] seg;
        case (nib)
            4'h0:    seg = 7'b0000001;
            4'h1:    seg = 7'b1001111;
            4'h2:    seg = 7'b0010010;
            4'h3:    seg = 7'b0000110;
            4'h4:    seg = 7'b1001100;
            4'h5:    seg = 7'b0100100;
            4'h6:    seg = 7'b0100000;
            4'h7:    seg = 7'b0001111;
            4'h8:    seg = 7'b0000000;
            4'h9:    seg = 7'b0000100;
            4'hA:    seg = 7'b0001000;
            4'hB:    seg = 7'b1100000;
            4'hC:    seg = 7'b0110001;
            4'hD:    seg = 7'b1000010;
            4'hE:    seg = 7'b0110000;
            4'hF:    seg = 7'b0111000;
            default: seg = SEG_BLANK;
        endcase
        return seg;
    endfunction

    // Leading-zero suppression applies only to the high digit.
    function automatic logic [6:0] hi_decode(input logic [7:0] value, input logic blank);
        logic [6:0] seg;
        if (blank && (value[7:4] == 4'h0)) begin
            seg = SEG_BLANK;
        end else begin
            seg = seg_decode(value[7:4]);
        end
        return seg;
    endfunction

    state_t             state_r;
    logic [NUM_REQ-1:0] grant_r;
    logic [NUM_REQ-1:0] done_r;
    logic               busy_r;
    logic [IDX_W-1:0]   last_grant_r;
    logic [CNT_W-1:0]   hold_cnt_r;
    logic [6:0]         disp1_r;
    logic [6:0]         disp2_r;

    logic [NUM_REQ-1:0] cand_s;
    logic               cand_any_s;
    logic               owner_valid_s;
    logic [IDX_W-1:0]   winner_s;
    logic [7:0]         owner_value_s;
    logic [7:0]         winner_value_s;
    logic [6:0]         owner_d1_s;
    logic [6:0]         owner_d2_s;
    logic [6:0]         winner_d1_s;
    logic [6:0]         winner_d2_s;

    // Candidate set, round-robin winner among non-owners, and decoded patterns for owner and winner.
    always_comb begin : arb_comb
        int scan;
        scan          = 0;
        cand_s        = bus.req_valid & ~grant_r;
        cand_any_s    = |cand_s;
        owner_valid_s = bus.req_valid[last_grant_r];
        winner_s      = last_grant_r;
        // Scanning from the far end down lets the nearest valid index after last_grant win.
        for (int off = NUM_REQ; off >= 1; off--) begin
            scan     = (int'(last_grant_r) + off) % NUM_REQ;
            winner_s = cand_s[scan[IDX_W-1:0]] ? scan[IDX_W-1:0] : winner_s;
        end
        owner_value_s  = bus.req_value[{last_grant_r, 3'b000} +: 8];
        winner_value_s = bus.req_value[{winner_s, 3'b000} +: 8];
        owner_d1_s     = seg_decode(owner_value_s[3:0]);
        owner_d2_s     = hi_decode(owner_value_s, bus.req_blank[last_grant_r]);
        winner_d1_s    = seg_decode(winner_value_s[3:0]);
        winner_d2_s    = hi_decode(winner_value_s, bus.req_blank[winner_s]);
    end

    // Slot FSM: grants, hold counter, preemption notice and registered display patterns.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r      <= IDLE;
            grant_r      <= NONE;
            done_r       <= NONE;
            busy_r       <= 1'b0;
            last_grant_r <= IDX_W'(NUM_REQ - 1);
            hold_cnt_r   <= {CNT_W{1'b0}};
            disp1_r      <= SEG_BLANK;
            disp2_r      <= SEG_BLANK;
        end else begin
            done_r <= NONE;
            case (state_r)
                IDLE: begin
                    if (cand_any_s) begin
                        state_r      <= SHOW;
                        grant_r      <= ONE_HOT0 << winner_s;
                        busy_r       <= 1'b1;
                        last_grant_r <= winner_s;
                        hold_cnt_r   <= {CNT_W{1'b0}};
                        disp1_r      <= winner_d1_s;
                        disp2_r      <= winner_d2_s;
                    end else begin
                        grant_r <= NONE;
                        busy_r  <= 1'b0;
                        disp1_r <= SEG_BLANK;
                        disp2_r <= SEG_BLANK;
                    end
                end
                SHOW: begin
                    // A pending done pulse means the slot already expired with a competitor waiting.
                    if ((!owner_valid_s || (done_r != NONE)) && cand_any_s) begin
                        grant_r      <= ONE_HOT0 << winner_s;
                        last_grant_r <= winner_s;
                        hold_cnt_r   <= {CNT_W{1'b0}};
                        disp1_r      <= winner_d1_s;
                        disp2_r      <= winner_d2_s;
                    end else if (!owner_valid_s) begin
                        state_r    <= IDLE;
                        grant_r    <= NONE;
                        busy_r     <= 1'b0;
                        hold_cnt_r <= {CNT_W{1'b0}};
                        disp1_r    <= SEG_BLANK;
                        disp2_r    <= SEG_BLANK;
                    end else begin
                        hold_cnt_r <= (hold_cnt_r == HOLD_LAST) ? HOLD_LAST : hold_cnt_r + 1'b1;
                        disp1_r    <= owner_d1_s;
                        disp2_r    <= owner_d2_s;
                        // Notify during the last held cycle so the handover lands right after it.
                        if (cand_any_s && (hold_cnt_r >= HOLD_WARN)) begin
                            done_r <= grant_r;
                        end else begin
                            done_r <= NONE;
                        end
                    end
                end
                default: begin
                    state_r <= IDLE;
                    grant_r <= NONE;
                    busy_r  <= 1'b0;
                    disp1_r <= SEG_BLANK;
                    disp2_r <= SEG_BLANK;
                end
            endcase
        end
    end

    assign bus.grant     = grant_r;
    assign bus.done      = done_r;
    assign bus.busy      = busy_r;
    assign bus.display_1 = disp1_r;
    assign bus.display_2 = disp2_r;

endmodule
